// File: rtl/lcd_controller_if.sv
// Byte handshake from the core and LCD pin bundle.
// The controller takes the slave side.
interface lcd_controller_if;
  logic [7:0] iData;
  logic       iRS;
  logic       iWrite;
  logic       oReady;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  modport master (
    output iData, iRS, iWrite,
    input  oReady, oLCD_E, oLCD_RS,
    input  oLCD_RW, oLCD_Data
  );

  modport slave (
    input  iData, iRS, iWrite,
    output oReady, oLCD_E, oLCD_RS,
    output oLCD_RW, oLCD_Data
  );
endinterface

// File: rtl/lcd_controller.sv
// 4-bit character-LCD sequencer: power-on init, config,
// then one byte per ready/write handshake as two nibbles.
module lcd_controller #(
  parameter int T_POWERUP = 750000,
  parameter int T_4MS     = 205000,
  parameter int T_100US   = 5000,
  parameter int T_40US    = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_E       = 12,
  parameter int T_NIB     = 50
) (
  input logic Clock,
  input logic Reset,
  lcd_controller_if.slave bus
);

  localparam logic [3:0] PWR_WAIT   = 4'd0;
  localparam logic [3:0] INIT_SETUP = 4'd1;
  localparam logic [3:0] INIT_E     = 4'd2;
  localparam logic [3:0] INIT_WAIT  = 4'd3;
  localparam logic [3:0] IDLE       = 4'd4;
  localparam logic [3:0] HI_SETUP   = 4'd5;
  localparam logic [3:0] HI_E       = 4'd6;
  localparam logic [3:0] GAP        = 4'd7;
  localparam logic [3:0] LO_SETUP   = 4'd8;
  localparam logic [3:0] LO_E       = 4'd9;
  localparam logic [3:0] EXEC       = 4'd10;

  // counter reload values are duration-1: a state
  // leaves on the edge where the count is zero
  localparam logic [19:0] C_PWR   = 20'(T_POWERUP - 1);
  localparam logic [19:0] C_4MS   = 20'(T_4MS - 1);
  localparam logic [19:0] C_100US = 20'(T_100US - 1);
  localparam logic [19:0] C_40US  = 20'(T_40US - 1);
  localparam logic [19:0] C_CLEAR = 20'(T_CLEAR - 1);
  localparam logic [19:0] C_SETUP = 20'(T_SETUP - 1);
  localparam logic [19:0] C_E     = 20'(T_E - 1);
  localparam logic [19:0] C_NIB   = 20'(T_NIB - 1);

  logic [3:0]  st, nst;
  logic [19:0] cnt, ncnt;
  logic [7:0]  byt, nbyt;
  logic        rsq, nrs;
  logic [1:0]  ini, nini;
  logic [1:0]  cix, ncix;
  logic        cfg, ncfg;
  logic        adv, clr;
  logic        e_q, ne;
  logic        rdy_q;
  logic [3:0]  d_q, nd;

  function automatic logic [7:0] cfg_byte(
    input logic [1:0] i
  );
    unique case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [3:0] init_nib(
    input logic [1:0] i
  );
    return (i == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [19:0] init_wait(
    input logic [1:0] i
  );
    unique case (i)
      2'd0:    return C_4MS;
      2'd1:    return C_100US;
      default: return C_40US;
    endcase
  endfunction

  assign adv = (cnt == 20'd0);
  assign clr = !nrs && (nbyt == 8'h01 ||
               nbyt == 8'h02 || nbyt == 8'h03);

  // next-state and byte/phase bookkeeping
  always_comb begin
    nst  = st;
    nbyt = byt;
    nrs  = rsq;
    nini = ini;
    ncix = cix;
    ncfg = cfg;
    unique case (st)
      PWR_WAIT:
        if (adv) begin
          nst  = INIT_SETUP;
          nini = 2'd0;
        end
      INIT_SETUP: if (adv) nst = INIT_E;
      INIT_E:     if (adv) nst = INIT_WAIT;
      INIT_WAIT:
        if (adv) begin
          if (ini == 2'd3) begin
            nst  = HI_SETUP;
            ncfg = 1'b1;
            ncix = 2'd0;
            nbyt = cfg_byte(2'd0);
            nrs  = 1'b0;
          end else begin
            nst  = INIT_SETUP;
            nini = ini + 2'd1;
          end
        end
      IDLE:
        if (bus.iWrite) begin
          nst  = HI_SETUP;
          nbyt = bus.iData;
          nrs  = bus.iRS;
        end
      HI_SETUP: if (adv) nst = HI_E;
      HI_E:     if (adv) nst = GAP;
      GAP:      if (adv) nst = LO_SETUP;
      LO_SETUP: if (adv) nst = LO_E;
      LO_E:     if (adv) nst = EXEC;
      EXEC:
        if (adv) begin
          if (cfg && cix != 2'd3) begin
            nst  = HI_SETUP;
            ncix = cix + 2'd1;
            nbyt = cfg_byte(cix + 2'd1);
          end else begin
            nst  = IDLE;
            ncfg = 1'b0;
          end
        end
      default: nst = PWR_WAIT;
    endcase
  end

  // shared counter: reload on entry, else count down
  always_comb begin
    ncnt = 20'd0;
    if (nst == st && nst != IDLE) begin
      ncnt = cnt - 20'd1;
    end else begin
      unique case (nst)
        INIT_SETUP, HI_SETUP, LO_SETUP: ncnt = C_SETUP;
        INIT_E, HI_E, LO_E:             ncnt = C_E;
        INIT_WAIT: ncnt = init_wait(nini);
        GAP:       ncnt = C_NIB;
        EXEC:      ncnt = clr ? C_CLEAR : C_40US;
        PWR_WAIT:  ncnt = C_PWR;
        default:   ncnt = 20'd0;
      endcase
    end
  end

  // pin values for the state being entered
  always_comb begin
    ne = (nst == INIT_E) || (nst == HI_E) ||
         (nst == LO_E);
    nd = 4'h0;
    unique case (nst)
      INIT_SETUP, INIT_E, INIT_WAIT:
        nd = init_nib(nini);
      HI_SETUP, HI_E, GAP:
        nd = nbyt[7:4];
      LO_SETUP, LO_E, EXEC, IDLE:
        nd = nbyt[3:0];
      default: nd = 4'h0;
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st    <= PWR_WAIT;
      cnt   <= C_PWR;
      byt   <= 8'h00;
      rsq   <= 1'b0;
      ini   <= 2'd0;
      cix   <= 2'd0;
      cfg   <= 1'b0;
      e_q   <= 1'b0;
      rdy_q <= 1'b0;
      d_q   <= 4'h0;
    end else begin
      st    <= nst;
      cnt   <= ncnt;
      byt   <= nbyt;
      rsq   <= nrs;
      ini   <= nini;
      cix   <= ncix;
      cfg   <= ncfg;
      e_q   <= ne;
      rdy_q <= (nst == IDLE);
      d_q   <= nd;
    end
  end

  assign bus.oReady    = rdy_q;
  assign bus.oLCD_E    = e_q;
  assign bus.oLCD_RS   = rsq;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oLCD_Data = d_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with a small
// E-pulse monitor and setup/hold watcher.
module tb_lcd_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails  = 0;

  lcd_controller_if bus ();

  lcd_controller #(
    .T_POWERUP(20), .T_4MS(10), .T_100US(6),
    .T_40US(4), .T_CLEAR(8), .T_SETUP(1),
    .T_E(3), .T_NIB(2)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [4:0] pn[$];
  int         pw[$];
  int         viol = 0;

  initial begin : monitor
    logic pe;
    logic [3:0] pd;
    logic prs;
    int wcnt;
    pe = 1'b0;
    pd = 4'h0;
    prs = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.oLCD_E === 1'b1 &&
          (bus.oLCD_Data !== pd ||
           bus.oLCD_RS !== prs))
        viol++;
      if (bus.oLCD_RW !== 1'b0 && !rst)
        viol++;
      if (bus.oLCD_E === 1'b1 && !pe) begin
        pn.push_back({bus.oLCD_RS, bus.oLCD_Data});
        wcnt = 1;
      end else if (bus.oLCD_E === 1'b1) begin
        wcnt++;
      end else if (pe) begin
        pw.push_back(wcnt);
      end
      pe  = (bus.oLCD_E === 1'b1);
      pd  = bus.oLCD_Data;
      prs = bus.oLCD_RS;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    pn.delete();
    pw.delete();
  endtask

  // release reset at a negedge, count edges to ready
  task automatic run_init(output int n);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 20) begin
        chk("pwr_no_e", 32'(bus.oLCD_E), 32'd0);
        chk("pwr_no_pulse", pn.size(), 0);
      end
    end while (bus.oReady !== 1'b1 && n < 400);
  endtask

  // one handshake; returns number of busy samples
  task automatic send(input logic [7:0] d,
                      input logic r,
                      output int low);
    @(negedge clk);
    clear_mon();
    bus.iData  = d;
    bus.iRS    = r;
    bus.iWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.iWrite = 1'b0;
    bus.iData  = 8'hxx;
    bus.iRS    = 1'bx;
    low = 0;
    while (bus.oReady !== 1'b1 && low < 400) begin
      low++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : main
    int n;
    int low;
    logic [3:0] ini_exp[12];
    logic [7:0] d;
    logic r;
    ini_exp = '{4'h3, 4'h3, 4'h3, 4'h2,
                4'h2, 4'h8, 4'h0, 4'h6,
                4'h0, 4'hC, 4'h0, 4'h1};
    bus.iData  = 8'h00;
    bus.iRS    = 1'b0;
    bus.iWrite = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.oReady), 32'd0);
    chk("rst_e", 32'(bus.oLCD_E), 32'd0);
    chk("rst_rs", 32'(bus.oLCD_RS), 32'd0);
    chk("rst_rw", 32'(bus.oLCD_RW), 32'd0);
    chk("rst_data", 32'(bus.oLCD_Data), 32'd0);

    run_init(n);
    chk("init_latency", n, 120);
    chk("init_pulses", pn.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("init_nib%0d", i),
          32'(pn[i]), 32'({1'b0, ini_exp[i]}));
      chk($sformatf("init_w%0d", i), pw[i], 3);
    end

    send(8'h48, 1'b1, low);
    chk("char_busy", low, 14);
    chk("char_pulses", pn.size(), 2);
    chk("char_hi", 32'(pn[0]), 32'h14);
    chk("char_lo", 32'(pn[1]), 32'h18);
    chk("char_w0", pw[0], 3);
    chk("char_w1", pw[1], 3);

    send(8'h01, 1'b0, low);
    chk("clr_busy", low, 18);
    chk("clr_hi", 32'(pn[0]), 32'h00);
    chk("clr_lo", 32'(pn[1]), 32'h01);

    @(negedge clk);
    clear_mon();
    bus.iData  = 8'h41;
    bus.iRS    = 1'b1;
    bus.iWrite = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    bus.iWrite = 1'b0;
    chk("hold_ready", 32'(bus.oReady), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pulses", pn.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("hold_nib%0d", i), 32'(pn[i]),
          (i % 2 == 0) ? 32'h14 : 32'h11);

    @(negedge clk);
    bus.iData  = 8'h55;
    bus.iRS    = 1'b1;
    bus.iWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.iWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_in_e", 32'(bus.oLCD_E), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_e", 32'(bus.oLCD_E), 32'd0);
    chk("mid_rst_ready", 32'(bus.oReady), 32'd0);
    chk("mid_rst_data", 32'(bus.oLCD_Data), 32'd0);
    repeat (2) @(posedge clk);
    run_init(n);
    chk("reinit_latency", n, 120);
    chk("reinit_pulses", pn.size(), 12);
    chk("reinit_last", 32'(pn[11]), 32'h01);

    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom_range(0, 255));
      r = 1'($urandom_range(0, 1));
      if (k % 4 == 0) begin
        d = 8'(k / 4 + 1);
        r = 1'b0;
      end
      send(d, r, low);
      chk($sformatf("rnd_busy%0d", k), low,
          (!r && d >= 8'd1 && d <= 8'd3) ? 18 : 14);
      chk($sformatf("rnd_hi%0d", k), 32'(pn[0]),
          32'({r, d[7:4]}));
      chk($sformatf("rnd_lo%0d", k), 32'(pn[1]),
          32'({r, d[3:0]}));
    end
    chk("setup_hold_rw", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
